alu_result_fifo: RTL

Downstream buffer for the `sixteen_bit_alu`. It captures each ALU result, together with its `zero`/`overflow` flags and the `alu_ctrl` code that produced it, into a small show-ahead FIFO. A consumer (writeback or display logic) drains the FIFO with a valid/ready handshake. The block also keeps a sticky overflow status, and optionally a count of pushes dropped while the FIFO was full.

---
 rtl/alu_result_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Purpose  : Show-ahead FIFO that buffers ALU results with their zero/overflow
//            flags and ctrl code, plus a sticky overflow flag. An optional
//            saturating drop counter is enabled by defining ALU_FIFO_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  input  logic [3:0]               in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic                     out_overflow,
  output logic [3:0]               out_ctrl,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  input  logic                     ovf_clear,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 6;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  // Entry layout: {ctrl, overflow, zero, result}
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf_sticky;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_head;

  // Handshake flags come only from registered occupancy; no pass-through paths.
  assign w_in_ready  = (r_count != c_FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  // Storage is intentionally not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {in_ctrl, in_overflow, in_zero, in_result};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_push && in_overflow) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clear) begin
      r_ovf_sticky <= 1'b0;
    end
  end

`ifdef ALU_FIFO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (in_valid && !w_in_ready && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = 8'd0;
`endif

  assign w_head       = r_mem[r_rd_ptr];
  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_result   = w_out_valid ? w_head[WIDTH-1:0] : '0;
  assign out_zero     = w_out_valid ? w_head[WIDTH]     : 1'b0;
  assign out_overflow = w_out_valid ? w_head[WIDTH+1]   : 1'b0;
  assign out_ctrl     = w_out_valid ? w_head[EW-1:WIDTH+2] : 4'd0;
  assign count        = r_count;
  assign ovf_sticky   = r_ovf_sticky;

endmodule
`default_nettype wire
